// File: rtl/alu_pkg.sv
// ============================================================================
// Package     : alu_pkg
// Description : Shared opcodes and types for the 4-bit ALU and its command
//               sequencer. Holds the opcode encoding, the default-width
//               command record, and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Native datapath widths of the ALU this sequencer feeds.
  localparam int ALU_W    = 4;
  localparam int ALU_SELW = 3;

  // Opcode encoding shared with the ALU.
  localparam logic [ALU_SELW-1:0] OP_ADD  = 3'd0;
  localparam logic [ALU_SELW-1:0] OP_SUB  = 3'd1;
  localparam logic [ALU_SELW-1:0] OP_AND  = 3'd2;
  localparam logic [ALU_SELW-1:0] OP_OR   = 3'd3;
  localparam logic [ALU_SELW-1:0] OP_XOR  = 3'd4;
  localparam logic [ALU_SELW-1:0] OP_NAND = 3'd5;
  localparam logic [ALU_SELW-1:0] OP_NOR  = 3'd6;
  localparam logic [ALU_SELW-1:0] OP_XNOR = 3'd7;

  // One queued ALU operation at the native widths.
  typedef struct packed {
    logic [ALU_W-1:0]    a;
    logic [ALU_W-1:0]    b;
    logic [ALU_SELW-1:0] sel;
  } alu_cmd_t;

  // Issue FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } seq_state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Command FIFO for the ALU sequencer. Registered storage with
//               wrapping read/write pointers and an occupancy counter; the
//               head entry is read straight from storage (no write-through).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               push_i/push_data_i - write request and command (ignored when full)
//               pop_i/pop_data_o   - read request (ignored when empty) and head
//               full_o/empty_o     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,          // power of two, >= 2
  parameter type cmd_t = alu_cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  cmd_t push_data_i,
  input  logic pop_i,
  output cmd_t pop_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int               PTR_W  = $clog2(DEPTH);
  localparam int               CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign full_o     = (count_q == C_FULL);
  assign empty_o    = (count_q == '0);
  assign push_en    = push_i & ~full_o;
  assign pop_en     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule : alu_cmd_fifo

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Issue stage for the external 4-bit combinational ALU. Queues
//               commands, drives one at a time onto registered ALU inputs,
//               captures Y/carry one cycle later and offers the result on a
//               valid/ready port together with its opcode.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               cmd_valid_i/cmd_ready_o   - command handshake
//               cmd_a_i/cmd_b_i/cmd_sel_i - command payload
//               alu_a_o/alu_b_o/alu_sel_o - registered ALU operands/opcode
//               alu_y_i/alu_carry_i       - ALU result (combinational)
//               res_valid_o/res_ready_i   - result handshake
//               res_y_o/res_carry_o/res_sel_o - captured result and opcode
//               res_zero_o                - zero flag (STATUS_FLAGS_EN only)
// Config      : define STATUS_FLAGS_EN to add the res_zero_o port and flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,     // must match the ALU
  parameter int SELW  = ALU_SELW,  // must match the ALU
  parameter int DEPTH = 4          // power of two, >= 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [W-1:0]    cmd_a_i,
  input  logic [W-1:0]    cmd_b_i,
  input  logic [SELW-1:0] cmd_sel_i,
  output logic [W-1:0]    alu_a_o,
  output logic [W-1:0]    alu_b_o,
  output logic [SELW-1:0] alu_sel_o,
  input  logic [W-1:0]    alu_y_i,
  input  logic            alu_carry_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [W-1:0]    res_y_o,
  output logic            res_carry_o,
`ifdef STATUS_FLAGS_EN
  output logic            res_zero_o,
`endif
  output logic [SELW-1:0] res_sel_o
);

  // Command record at this instance's widths.
  typedef struct packed {
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [SELW-1:0] sel;
  } cmd_t;

  cmd_t       push_data;
  cmd_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       capture;
  logic       res_take;

  seq_state_t      state_q, state_d;
  logic [W-1:0]    alu_a_q, alu_b_q;
  logic [SELW-1:0] alu_sel_q;
  logic            res_valid_q;
  logic [W-1:0]    res_y_q;
  logic            res_carry_q;
  logic [SELW-1:0] res_sel_q;

  // Held low during reset so nothing is accepted into a FIFO being cleared.
  assign cmd_ready_o = ~fifo_full & ~rst;
  assign fifo_push   = cmd_valid_i & cmd_ready_o;
  assign push_data   = '{a: cmd_a_i, b: cmd_b_i, sel: cmd_sel_i};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .cmd_t (cmd_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (push_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Issue FSM: IDLE waits for work, EXEC lets the ALU settle for one cycle,
  // RESULT holds the captured result until the consumer takes it. Popping on
  // the same cycle the result leaves gives one result every two cycles.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;
    res_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESULT;
      end
      RESULT: begin
        if (res_ready_i) begin
          res_take = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = EXEC;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_carry_q <= 1'b0;
      res_sel_q   <= '0;
    end else begin
      state_q <= state_d;
      // Operand registers only change on a pop, so the ALU inputs stay
      // quiet in IDLE and RESULT.
      if (fifo_pop) begin
        alu_a_q   <= head.a;
        alu_b_q   <= head.b;
        alu_sel_q <= head.sel;
      end
      if (capture) begin
        res_y_q     <= alu_y_i;
        res_carry_q <= alu_carry_i;
        res_sel_q   <= alu_sel_q;
        res_valid_q <= 1'b1;
      end else if (res_take) begin
        res_valid_q <= 1'b0;
      end
    end
  end

`ifdef STATUS_FLAGS_EN
  logic res_zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_zero_q <= 1'b0;
    end else if (capture) begin
      res_zero_q <= (alu_y_i == '0);
    end
  end

  assign res_zero_o = res_zero_q;
`endif

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_sel_o   = alu_sel_q;
  assign res_valid_o = res_valid_q;
  assign res_y_o     = res_y_q;
  assign res_carry_o = res_carry_q;
  assign res_sel_o   = res_sel_q;

endmodule : alu_cmd_sequencer

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer. Models the ALU
//               behaviourally, drives directed and random command streams,
//               and checks results in order through an expected-result queue.
// Config      : honours STATUS_FLAGS_EN (res_zero_o connected and checked).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_sel = '0;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_sel;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_y;
  logic       res_carry;
  logic [2:0] res_sel;
  logic       res_zero;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] y;
    logic       c;
    logic [2:0] sel;
    logic       z;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, y}. Subtraction reports a borrow as carry.
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s);
    int ia = int'(a);
    int ib = int'(b);
    case (s)
      OP_ADD:  return 5'(ia + ib);
      OP_SUB:  return {(ia < ib) ? 1'b1 : 1'b0, 4'(ia - ib)};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NAND: return {1'b0, ~(a & b)};
      OP_NOR:  return {1'b0, ~(a | b)};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  assign {alu_carry, alu_y} = alu_ref(alu_a, alu_b, alu_sel);

  alu_cmd_sequencer #(
    .W     (4),
    .SELW  (3),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_sel_i   (cmd_sel),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_sel_o   (alu_sel),
    .alu_y_i     (alu_y),
    .alu_carry_i (alu_carry),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_y_o     (res_y),
    .res_carry_o (res_carry),
`ifdef STATUS_FLAGS_EN
    .res_zero_o  (res_zero),
`endif
    .res_sel_o   (res_sel)
  );

`ifndef STATUS_FLAGS_EN
  assign res_zero = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard/monitor. Inputs only change 1 time unit after a rising edge,
  // so at the falling edge every handshake for the coming edge is settled.
  exp_t       e;
  logic [4:0] r;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        r = alu_ref(cmd_a, cmd_b, cmd_sel);
        exp_q.push_back('{y: r[3:0], c: r[4], sel: cmd_sel, z: (r[3:0] == 4'h0)});
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got y=%0h sel=%0h expected no result", res_y, res_sel);
        end else begin
          // Checked every cycle it is presented, so a stall also checks stability.
          e = exp_q[0];
          check("res_y", 32'(res_y), 32'(e.y));
          check("res_carry", 32'(res_carry), 32'(e.c));
          check("res_sel", 32'(res_sel), 32'(e.sel));
`ifdef STATUS_FLAGS_EN
          check("res_zero", 32'(res_zero), 32'(e.z));
`endif
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and hold it until accepted (bounded).
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = s;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("send_timeout", 32'(0), 32'(1));
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      step();
      t++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  int accepted;
  int t;

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("post_rst_alu_a", 32'(alu_a), 32'(0));
    check("post_rst_res_y", 32'(res_y), 32'(0));

    // ---------------- 1: latency of a single ADD ----------------
    res_ready = 1'b1;
    step();
    send(4'd5, 4'd3, OP_ADD);
    @(negedge clk);
    check("lat_k_res_valid", 32'(res_valid), 32'(0));
    check("lat_k_alu_a_not_loaded", 32'(alu_a), 32'(0));
    @(negedge clk);
    check("lat_k1_res_valid", 32'(res_valid), 32'(0));
    check("lat_k1_alu_a", 32'(alu_a), 32'(5));
    check("lat_k1_alu_b", 32'(alu_b), 32'(3));
    @(negedge clk);
    check("lat_k2_res_valid", 32'(res_valid), 32'(1));
    check("lat_k2_res_y", 32'(res_y), 32'(8));
    wait_drain();

    // ---------------- 2: ADD overflow to zero ----------------
    send(4'hF, 4'h1, OP_ADD);
    wait_drain();

    // ---------------- 3: backpressure fills the FIFO ----------------
    res_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      cmd_valid = 1'b1;
      cmd_a     = 4'(i + 1);
      cmd_b     = 4'(9 - i);
      cmd_sel   = 3'(i);
      @(negedge clk);
      if (cmd_ready) accepted++;
      step();
    end
    cmd_valid = 1'b0;
    check("full_accept_count", 32'(accepted), 32'(DEPTH + 1));
    @(negedge clk);
    check("full_cmd_ready", 32'(cmd_ready), 32'(0));
    check("full_res_valid_held", 32'(res_valid), 32'(1));
    step();
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(4'(i + 10), 4'(i + 2), OP_SUB);
    wait_drain();

    // ---------------- 4: every opcode on 0101/0011 ----------------
    for (int s = 0; s < 8; s++) send(4'b0101, 4'b0011, 3'(s));
    wait_drain();

    // ---------------- 5: random full-rate / stalled stream ----------------
    for (int i = 0; i < 150; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_a     = 4'($urandom_range(0, 15));
      cmd_b     = 4'($urandom_range(0, 15));
      cmd_sel   = 3'($urandom_range(0, 7));
      res_ready = (i < 50) ? 1'b1 : ($urandom_range(0, 3) != 0);
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain();

    // ---------------- 6: reset with queued work and a held result ----------------
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i + 3), 4'(i), OP_XOR);
    t = 0;
    @(negedge clk);
    while (!res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("pre_rst_res_valid", 32'(res_valid), 32'(1));
    step();
    rst = 1'b1;
    @(negedge clk);
    check("in_rst_cmd_ready", 32'(cmd_ready), 32'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_res_valid", 32'(res_valid), 32'(0));
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("mid_rst_alu_a", 32'(alu_a), 32'(0));
    check("mid_rst_alu_b", 32'(alu_b), 32'(0));
    check("mid_rst_alu_sel", 32'(alu_sel), 32'(0));
    check("mid_rst_res_y", 32'(res_y), 32'(0));
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_res_valid", 32'(res_valid), 32'(0));
      check("no_stale_alu_a", 32'(alu_a), 32'(0));
    end

    // Fresh traffic after the mid-run reset.
    for (int i = 0; i < 4; i++) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                     3'($urandom_range(0, 7)));
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_cmd_sequencer

`default_nettype wire
